// File: rtl/control_sequencer_pkg.sv
// Shared types for the control sequencer: FSM states, instruction classes, branch conditions, field positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package control_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2
    } state_t;

    localparam logic [1:0] CLS_ALU_REG = 2'b00;
    localparam logic [1:0] CLS_ALU_IMM = 2'b01;
    localparam logic [1:0] CLS_MEM     = 2'b10;
    localparam logic [1:0] CLS_BRANCH  = 2'b11;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_N      = 2'b10;
    localparam logic [1:0] COND_NZ     = 2'b11;

    localparam int CLS_HI     = 15;
    localparam int CLS_LO     = 14;
    localparam int FS_HI      = 13;
    localparam int FS_LO      = 10;
    localparam int MEM_ST_BIT = 13;
    localparam int COND_HI    = 13;
    localparam int COND_LO    = 12;
    localparam int DR_HI      = 9;
    localparam int DR_LO      = 8;
    localparam int SA_HI      = 7;
    localparam int SA_LO      = 6;
    localparam int SB_HI      = 5;
    localparam int SB_LO      = 4;
    localparam int IMM_HI     = 7;
    localparam int IMM_LO     = 0;

    // Decoded control word; the top gates it by FSM state before driving pins.
    typedef struct packed {
        logic [1:0] aa;
        logic [1:0] ba;
        logic [1:0] da;
        logic [3:0] fs;
        logic [7:0] ci;
        logic       mb;
        logic       md;
        logic       is_alu;
        logic       is_mem;
        logic       is_store;
        logic       is_branch;
        logic [1:0] cond;
        logic [7:0] target;
    } ctrl_t;

    function automatic logic cond_met(input logic [1:0] cond, input logic n, input logic z);
        case (cond)
            COND_ALWAYS: cond_met = 1'b1;
            COND_Z:      cond_met = z;
            COND_N:      cond_met = n;
            default:     cond_met = ~z;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Combinational decode of the instruction register into datapath select fields.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows IR directly.
module control_sequencer_instr_decode
    import control_sequencer_pkg::*;
(
    input  logic [15:0] ir,
    output ctrl_t       ctrl
);

    logic [1:0] cls;
    assign cls = ir[CLS_HI:CLS_LO];

    // Map each instruction class onto its selects; fields a class does not use stay 0.
    always_comb begin
        ctrl        = '0;
        ctrl.cond   = ir[COND_HI:COND_LO];
        ctrl.target = ir[IMM_HI:IMM_LO];
        case (cls)
            CLS_ALU_REG: begin
                ctrl.da     = ir[DR_HI:DR_LO];
                ctrl.aa     = ir[SA_HI:SA_LO];
                ctrl.ba     = ir[SB_HI:SB_LO];
                ctrl.fs     = ir[FS_HI:FS_LO];
                ctrl.is_alu = 1'b1;
            end
            CLS_ALU_IMM: begin
                // Two-address form: destination is also the A operand.
                ctrl.da     = ir[DR_HI:DR_LO];
                ctrl.aa     = ir[DR_HI:DR_LO];
                ctrl.ci     = ir[IMM_HI:IMM_LO];
                ctrl.fs     = ir[FS_HI:FS_LO];
                ctrl.mb     = 1'b1;
                ctrl.is_alu = 1'b1;
            end
            CLS_MEM: begin
                ctrl.is_mem = 1'b1;
                ctrl.aa     = ir[SA_HI:SA_LO];
                if (ir[MEM_ST_BIT]) begin
                    ctrl.is_store = 1'b1;
                    ctrl.ba       = ir[SB_HI:SB_LO];
                end else begin
                    ctrl.da = ir[DR_HI:DR_LO];
                    ctrl.md = 1'b1;
                end
            end
            default: begin
                ctrl.is_branch = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute/memory sequencer driving a register-file datapath from 16-bit instructions.
// Latency: ALU/branch 2 cycles + fetch wait; load/store 3 cycles + fetch and data waits.
// Backpressure: req held with stable address/controls until ack; acks without a req are ignored.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [1:0]  AA,
    output logic [1:0]  BA,
    output logic [1:0]  DA,
    output logic [3:0]  FS,
    output logic [7:0]  CI,
    output logic        LE,
    output logic        MD,
    output logic        MB,
    input  logic        N,
    input  logic        Z,
    output logic [7:0]  pc
);

    state_t      state, state_nxt;
    logic [15:0] ir, ir_nxt;
    logic [7:0]  pc_nxt;
    logic        flag_n, flag_z, flag_n_nxt, flag_z_nxt;
    logic        run;
    ctrl_t       ctrl;

    control_sequencer_instr_decode u_decode (
        .ir   (ir),
        .ctrl (ctrl)
    );

    // State, pc, IR and flags; run holds off the first fetch until one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_FETCH;
            pc     <= 8'd0;
            ir     <= 16'd0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            run    <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            ir     <= ir_nxt;
            flag_n <= flag_n_nxt;
            flag_z <= flag_z_nxt;
            run    <= 1'b1;
        end
    end

    // Next-state and output decode; selects are only driven outside FETCH.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ir_nxt     = ir;
        flag_n_nxt = flag_n;
        flag_z_nxt = flag_z;
        imem_req   = 1'b0;
        imem_addr  = pc;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        AA         = 2'd0;
        BA         = 2'd0;
        DA         = 2'd0;
        FS         = 4'd0;
        CI         = 8'd0;
        LE         = 1'b0;
        MD         = 1'b0;
        MB         = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = run;
                if (run && imem_ack) begin
                    ir_nxt    = imem_data;
                    pc_nxt    = pc + 8'd1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                AA = ctrl.aa;
                BA = ctrl.ba;
                DA = ctrl.da;
                FS = ctrl.fs;
                CI = ctrl.ci;
                MB = ctrl.mb;
                LE = ctrl.is_alu;
                state_nxt = ctrl.is_mem ? ST_MEM : ST_FETCH;
                if (ctrl.is_alu) begin
                    flag_n_nxt = N;
                    flag_z_nxt = Z;
                end
                if (ctrl.is_branch && cond_met(ctrl.cond, flag_n, flag_z)) begin
                    pc_nxt = ctrl.target;
                end
            end
            ST_MEM: begin
                AA       = ctrl.aa;
                BA       = ctrl.ba;
                DA       = ctrl.da;
                dmem_req = 1'b1;
                dmem_we  = ctrl.is_store;
                if (dmem_ack) begin
                    // Load data is written back only in the cycle it arrives.
                    LE        = ~ctrl.is_store;
                    MD        = ctrl.md;
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with hand-computed expectations.
// Latency: n/a.
// Backpressure: memory acks driven with fixed wait counts.
module tb_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [1:0]  AA, BA, DA;
    logic [3:0]  FS;
    logic [7:0]  CI;
    logic        LE, MD, MB;
    logic        N, Z;
    logic [7:0]  pc;

    int n_tests;
    int n_fail;

    control_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .AA        (AA),
        .BA        (BA),
        .DA        (DA),
        .FS        (FS),
        .CI        (CI),
        .LE        (LE),
        .MD        (MD),
        .MB        (MB),
        .N         (N),
        .Z         (Z),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the fetch for 'waits' cycles, then ack with 'instr'; returns in EXEC.
    task automatic fetch(input logic [15:0] instr, input logic [7:0] addr, input int waits);
        logic [7:0] nxt;
        nxt = addr + 8'd1;
        for (int i = 0; i < waits; i++) begin
            check("fetch_wait_req", {15'd0, imem_req}, 16'd1);
            check("fetch_wait_le", {15'd0, LE}, 16'd0);
            check("fetch_wait_addr", {8'd0, imem_addr}, {8'd0, addr});
            step();
        end
        imem_ack  = 1'b1;
        imem_data = instr;
        #1;
        check("fetch_req", {15'd0, imem_req}, 16'd1);
        check("fetch_addr", {8'd0, imem_addr}, {8'd0, addr});
        step();
        imem_ack  = 1'b0;
        imem_data = 16'h0;
        #1;
        check("fetch_pc_inc", {8'd0, pc}, {8'd0, nxt});
        check("exec_no_req", {15'd0, imem_req}, 16'd0);
    endtask

    // Execute one ALU instruction with the given datapath flags.
    task automatic run_alu(input logic [15:0] instr, input logic [7:0] addr, input logic n, input logic z);
        fetch(instr, addr, 0);
        N = n;
        Z = z;
        #1;
        check("alu_le", {15'd0, LE}, 16'd1);
        step();
        N = 1'b0;
        Z = 1'b0;
        check("alu_le_drop", {15'd0, LE}, 16'd0);
    endtask

    // Execute a branch and check the resulting fetch address.
    task automatic run_branch(input logic [15:0] instr, input logic [7:0] addr, input logic [7:0] exp_pc);
        fetch(instr, addr, 0);
        check("br_le", {15'd0, LE}, 16'd0);
        step();
        check("br_pc", {8'd0, pc}, {8'd0, exp_pc});
        check("br_fetch_addr", {8'd0, imem_addr}, {8'd0, exp_pc});
    endtask

    initial begin
        int req_cycles;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0;
        dmem_ack  = 1'b0;
        N         = 1'b0;
        Z         = 1'b0;
        #1;
        check("rst_imem_req", {15'd0, imem_req}, 16'd0);
        check("rst_dmem_req", {15'd0, dmem_req}, 16'd0);
        check("rst_le", {15'd0, LE}, 16'd0);
        check("rst_pc", {8'd0, pc}, 16'd0);
        check("rst_selects", {AA, BA, DA, FS, MB, MD, dmem_we, 1'b0}, 16'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_no_req_yet", {15'd0, imem_req}, 16'd0);
        step();
        check("first_req", {15'd0, imem_req}, 16'd1);

        // ALU-reg 0x0A12 after two waits: FS=2 DR=2 SA=0 SB=1.
        fetch(16'h0A12, 8'h00, 2);
        check("r_le", {15'd0, LE}, 16'd1);
        check("r_da", {14'd0, DA}, 16'd2);
        check("r_aa", {14'd0, AA}, 16'd0);
        check("r_ba", {14'd0, BA}, 16'd1);
        check("r_fs", {12'd0, FS}, 16'd2);
        check("r_mb", {15'd0, MB}, 16'd0);
        check("r_md", {15'd0, MD}, 16'd0);
        step();
        check("r_le_once", {15'd0, LE}, 16'd0);
        check("r_next_addr", {8'd0, imem_addr}, 16'd1);

        // ALU-imm 0x4EAB: FS=3 DA=AA=2 CI=AB, sets Z.
        fetch(16'h4EAB, 8'h01, 0);
        Z = 1'b1;
        #1;
        check("i_le", {15'd0, LE}, 16'd1);
        check("i_da", {14'd0, DA}, 16'd2);
        check("i_aa", {14'd0, AA}, 16'd2);
        check("i_ci", {8'd0, CI}, 16'h00AB);
        check("i_mb", {15'd0, MB}, 16'd1);
        check("i_fs", {12'd0, FS}, 16'd3);
        step();
        Z = 1'b0;
        check("i_le_once", {15'd0, LE}, 16'd0);

        // Branch on Z: taken with stored Z=1, not taken after clearing Z.
        run_branch(16'hD040, 8'h02, 8'h40);
        run_alu(16'h0A12, 8'h40, 1'b0, 1'b0);
        run_branch(16'hD040, 8'h41, 8'h42);

        // Branch on N taken.
        run_alu(16'h4EAB, 8'h42, 1'b1, 1'b0);
        run_branch(16'hE080, 8'h43, 8'h80);

        // LOAD 0x8180 (DR=1 SA=2), ack after 3 waits; Z driven high must not reach flags.
        fetch(16'h8180, 8'h80, 0);
        Z = 1'b1;
        #1;
        check("ld_exec_le", {15'd0, LE}, 16'd0);
        check("ld_exec_dmem", {15'd0, dmem_req}, 16'd0);
        step();
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (dmem_req) req_cycles++;
            check("ld_wait_le", {15'd0, LE}, 16'd0);
            check("ld_wait_md", {15'd0, MD}, 16'd0);
            check("ld_wait_aa", {14'd0, AA}, 16'd2);
            step();
        end
        dmem_ack = 1'b1;
        #1;
        if (dmem_req) req_cycles++;
        check("ld_ack_le", {15'd0, LE}, 16'd1);
        check("ld_ack_md", {15'd0, MD}, 16'd1);
        check("ld_ack_da", {14'd0, DA}, 16'd1);
        check("ld_ack_we", {15'd0, dmem_we}, 16'd0);
        step();
        dmem_ack = 1'b0;
        Z = 1'b0;
        check("ld_req_cycles", req_cycles[15:0], 16'd4);
        check("ld_done_dmem", {15'd0, dmem_req}, 16'd0);
        check("ld_done_le", {15'd0, LE}, 16'd0);
        run_branch(16'hD040, 8'h81, 8'h82);

        // STORE 0xA070 (SA=1 SB=3), ack after one wait.
        fetch(16'hA070, 8'h82, 0);
        step();
        check("st_we", {15'd0, dmem_we}, 16'd1);
        check("st_aa", {14'd0, AA}, 16'd1);
        check("st_ba", {14'd0, BA}, 16'd3);
        step();
        dmem_ack = 1'b1;
        #1;
        check("st_ack_le", {15'd0, LE}, 16'd0);
        check("st_ack_req", {15'd0, dmem_req}, 16'd1);
        step();
        dmem_ack = 1'b0;
        check("st_done_we", {15'd0, dmem_we}, 16'd0);

        // Branch always to 0xFF, then fetch there wraps pc to 0.
        run_branch(16'hC0FF, 8'h83, 8'hFF);
        run_alu(16'h0A12, 8'hFF, 1'b0, 1'b0);
        check("wrap_pc", {8'd0, pc}, 16'd0);

        // Reset during a MEM wait, then a stray dmem_ack.
        fetch(16'h8180, 8'h00, 0);
        step();
        check("mid_dmem_req", {15'd0, dmem_req}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("arst_dmem_req", {15'd0, dmem_req}, 16'd0);
        check("arst_le", {15'd0, LE}, 16'd0);
        check("arst_pc", {8'd0, pc}, 16'd0);
        check("arst_selects", {AA, BA, DA, FS, MB, MD, dmem_we, 1'b0}, 16'd0);
        dmem_ack = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        check("rel2_no_req", {15'd0, imem_req}, 16'd0);
        check("stray_le", {15'd0, LE}, 16'd0);
        step();
        check("stray_dmem_req", {15'd0, dmem_req}, 16'd0);
        check("stray_le2", {15'd0, LE}, 16'd0);
        dmem_ack = 1'b0;
        fetch(16'h0A12, 8'h00, 1);
        check("resume_le", {15'd0, LE}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
